// File: rtl/im_seq_pkg.sv
// im_seq_pkg: op codes, sequencer state encoding and default frame geometry.
// Supplies a default for `IM_ISEL_W when the surrounding build does not define it.
`ifndef IM_ISEL_W
`define IM_ISEL_W 2
`endif

package im_seq_pkg;

    localparam logic [1:0] OP_COPY = 2'd0;
    localparam logic [1:0] OP_INV  = 2'd1;
    localparam logic [1:0] OP_THR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

endpackage

// File: rtl/im_pix_cnt.sv
// im_pix_cnt: linear pixel address counter; saturates at NPIX-1 and flags it.
module im_pix_cnt #(
    parameter int IM_ADDR_W = 19,
    parameter int NPIX      = 307200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    output logic [IM_ADDR_W-1:0] cnt,
    output logic                 last
);

    localparam logic [IM_ADDR_W-1:0] LAST_ADDR = IM_ADDR_W'(NPIX - 1);

    assign last = (cnt == LAST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/im_seq.sv
// im_seq: raster-scan ROM->RAM pixel sequencer (copy / invert / threshold).
// Define IM_SEQ_CSUM_EN to add the 16-bit write checksum output csum.
module im_seq
    import im_seq_pkg::*;
#(
    parameter int IM_DATA_W = 8,
    parameter int IM_ADDR_W = 19,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   hold,
    input  logic [1:0]             op,
    input  logic [IM_DATA_W-1:0]   thresh,
    input  logic [`IM_ISEL_W-1:0]  src_sel,
    output logic                   busy,
    output logic                   done,
`ifdef IM_SEQ_CSUM_EN
    output logic [15:0]            csum,
`endif
    output logic [`IM_ISEL_W-1:0]  isel,
    output logic                   r_en,
    output logic [IM_ADDR_W-1:0]   r_addr,
    input  logic [IM_DATA_W-1:0]   r_data,
    output logic                   w_en,
    output logic [IM_ADDR_W-1:0]   w_addr,
    output logic [IM_DATA_W-1:0]   w_data
);

    localparam int NPIX = IMG_W * IMG_H;

    state_t                 state;
    state_t                 state_nx;
    logic                   issue;
    logic                   launch;
    logic                   abort_act;
    logic                   pipe_empty;
    logic                   cnt_clr;
    logic                   cnt_last;
    logic [IM_ADDR_W-1:0]   cnt;
    logic [1:0]             op_q;
    logic [IM_DATA_W-1:0]   thr_q;
    logic                   vld_p1;
    logic [IM_ADDR_W-1:0]   addr_p1;

    function automatic logic [IM_DATA_W-1:0] pix_f(
        input logic [1:0]           op_sel,
        input logic [IM_DATA_W-1:0] px,
        input logic [IM_DATA_W-1:0] lvl
    );
        logic [IM_DATA_W-1:0] res;
        case (op_sel)
            OP_COPY: res = px;
            OP_INV:  res = ~px;
            OP_THR:  res = (px >= lvl) ? '1 : '0;
            default: res = px;
        endcase
        return res;
    endfunction

    im_pix_cnt #(
        .IM_ADDR_W (IM_ADDR_W),
        .NPIX      (NPIX)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (issue),
        .clr  (cnt_clr),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // The first read is issued on the same edge that samples start.
    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        launch     = 1'b0;
        abort_act  = abort && (state != IDLE);
        pipe_empty = !r_en && !vld_p1 && !w_en;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    issue    = 1'b1;
                    launch   = 1'b1;
                    state_nx = cnt_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (!hold) begin
                    issue = 1'b1;
                    if (cnt_last) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pipe_empty) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        cnt_clr = abort_act || (state == DONE);
    end

    // Stage 0: control, read issue and latched pass configuration.
    // Stage 2: write port, fed from stage 1 and the returning read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            isel   <= '0;
            op_q   <= OP_COPY;
            thr_q  <= '0;
            r_en   <= 1'b0;
            r_addr <= '0;
            vld_p1 <= 1'b0;
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx != IDLE);
            done   <= (state_nx == DONE);
            r_en   <= issue;
            vld_p1 <= r_en && !abort_act;
            w_en   <= vld_p1 && !abort_act;
            if (launch) begin
                isel  <= src_sel;
                op_q  <= op;
                thr_q <= thresh;
            end
            if (issue) begin
                r_addr <= cnt;
            end
            if (vld_p1) begin
                w_addr <= addr_p1;
                w_data <= pix_f(op_q, r_data, thr_q);
            end
        end
    end

    // Stage 1: address travels alongside the read in flight.
    always_ff @(posedge clk) begin
        addr_p1 <= r_addr;
    end

`ifdef IM_SEQ_CSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (launch) begin
            csum <= '0;
        end else if (w_en) begin
            csum <= csum + 16'(w_data);
        end
    end
`endif

endmodule
